// File: rtl/bcd2binary.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// bcd2binary
//   Multi-cycle packed-BCD to unsigned-binary converter using reverse
//   double-dabble. Decimal operands, such as keypad or display entry, are
//   converted back to binary for the gcd core. Only one conversion is in
//   flight at a time.
//
// Handshake (applies to both sides):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer holds its data stable while valid is high and ready is
//   low. Here, in_ready is high only in IDLE. out_valid stays high, with
//   bin_out/err stable, until a cycle where out_ready is high. bcd_in is
//   sampled only on the accepting edge.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high; overrides every other input
//   in_valid   bcd_in holds a value to convert
//   in_ready   block can accept (IDLE only)
//   bcd_in     packed BCD, digit 0 = bcd_in[3:0]
//   out_valid  bin_out/err hold a result; held until accepted
//   out_ready  downstream accepts the result
//   bin_out    converted value; forced to 0 when err is set
//   err        at least one input nibble was greater than 9
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// BIN_W must be at least ceil(log2(10**DIGITS)) and no wider than 4*DIGITS.
// ---------------------------------------------------------------------------
module bcd2binary #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err,
   output logic [1:0]            dbg_state
);

   localparam int SH_W  = 4 * DIGITS;
   localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SH_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [SH_W-1:0]    bcd_reg;
   logic [SH_W-1:0]    bin_reg;
   logic [CNT_W-1:0]   cnt;
   logic               err_reg;

   logic [SH_W-1:0]    bcd_half;
   logic [SH_W-1:0]    bcd_next;
   logic [SH_W-1:0]    bin_next;
   logic               in_err;

   assign dbg_state = state;

   // One reverse double-dabble step. The BCD register is halved as a whole.
   // Any nibble that received a 1 from its upper neighbour now reads as
   // 8 + x, when it should read as 5 + x, because a carried ten halves to
   // five. Subtracting 3 corrects that. A nibble is >= 8 exactly when its
   // MSB is set. The bit that falls out of the bottom becomes the next
   // binary bit, which enters from the top of bin_reg.
   always_comb begin
      bcd_half = bcd_reg >> 1;
      bcd_next = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_half[4*d+3])
            bcd_next[4*d +: 4] = bcd_half[4*d +: 4] - 4'd3;
         else
            bcd_next[4*d +: 4] = bcd_half[4*d +: 4];
      end
      bin_next = {bcd_reg[0], bin_reg[SH_W-1:1]};
   end

   // Illegal-digit detection on the incoming operand
   always_comb begin
      in_err = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_in[4*d +: 4] > 4'd9)
            in_err = 1'b1;
      end
   end

   // bin_reg[0] is shifted out and never read. The bits above BIN_W are
   // always zero for legal input, so they are dropped.
   generate
      if (BIN_W < SH_W) begin : g_drop_hi
         logic unused_bits;
         assign unused_bits = ^{bin_reg[0], bin_next[SH_W-1:BIN_W]};
      end else begin : g_keep_all
         logic unused_bits;
         assign unused_bits = bin_reg[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         bin_out   <= '0;
         err       <= 1'b0;
         bcd_reg   <= '0;
         bin_reg   <= '0;
         cnt       <= '0;
         err_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  bcd_reg  <= bcd_in;
                  bin_reg  <= '0;
                  cnt      <= '0;
                  err_reg  <= in_err;
               end
            end
            SHIFT: begin
               bin_reg <= bin_next;
               bcd_reg <= bcd_next;
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  bin_out   <= err_reg ? '0 : bin_next[BIN_W-1:0];
                  err       <= err_reg;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2binary.sv
`timescale 1ns / 1ps
// Self-checking bench for bcd2binary (DIGITS=3, BIN_W=10).
module tb_bcd2binary;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;
   localparam int SH_W   = 4 * DIGITS;
   localparam int LAT    = SH_W;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [SH_W-1:0]   bcd_in;
   logic              out_valid;
   logic              out_ready;
   logic [BIN_W-1:0]  bin_out;
   logic              err;
   logic [1:0]        dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd2binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [BIN_W-1:0] exp_q[$];
   logic             exp_err_q[$];

   // Reference: decimal value of the digits, or 0 with err if any digit > 9
   function automatic void ref_conv(input logic [SH_W-1:0] v,
                                    output logic [BIN_W-1:0] b,
                                    output logic e);
      int sum, p, d;
      sum = 0; p = 1; e = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         d = int'((v >> (4 * k)) & 12'hF);
         if (d > 9) e = 1'b1;
         sum += d * p;
         p *= 10;
      end
      b = e ? '0 : BIN_W'(sum);
   endfunction

   function automatic logic [SH_W-1:0] to_bcd(input int n);
      logic [SH_W-1:0] v;
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [SH_W-1:0] v);
      logic [BIN_W-1:0] b;
      logic e;
      ref_conv(v, b, e);
      exp_q.push_back(b);
      exp_err_q.push_back(e);
      bcd_in   = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      bcd_in   = SH_W'($urandom);
   endtask

   // Waits (bounded) for out_valid; n = cycles after the accepting edge
   task automatic wait_out(output int n, output bit ok);
      n = 0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bcd_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b bin_out=%0d err=%b, expected 1 0 0 0",
                  in_ready, out_valid, bin_out, err);
      end
   endtask

   task automatic test_single_999();
      int n; bit ok;
      logic [BIN_W-1:0] eb; logic ee;
      out_ready = 1'b1;
      send(12'h999);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL 999_in_ready_busy: got %b expected 0", in_ready);
      end
      wait_out(n, ok);
      eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (!ok || n != LAT) begin
         errors++;
         $display("FAIL 999_latency: got %0d (seen=%0b) expected %0d", n, ok, LAT);
      end
      checks++;
      if (bin_out !== eb || err !== ee) begin
         errors++;
         $display("FAIL 999_value: got %0d err=%b expected %0d err=%b", bin_out, err, eb, ee);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL 999_one_cycle: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [SH_W-1:0] vals[3];
      int t_prev, n;
      bit ok, busy_bad;
      logic [BIN_W-1:0] eb; logic ee;
      vals[0] = 12'h000; vals[1] = 12'h255; vals[2] = 12'h100;
      out_ready = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 3; k++) begin
         send(vals[k]);
         busy_bad = 1'b0; ok = 1'b0; n = 0;
         for (int i = 0; i < 40; i++) begin
            if (in_ready) busy_bad = 1'b1;
            tick();
            n++;
            if (out_valid) begin
               ok = 1'b1;
               break;
            end
         end
         if (in_ready) busy_bad = 1'b1;
         eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (!ok || bin_out !== eb || err !== ee) begin
            errors++;
            $display("FAIL b2b_value[%0d]: got %0d err=%b (seen=%0b) expected %0d err=%b",
                     k, bin_out, err, ok, eb, ee);
         end
         checks++;
         if (busy_bad) begin
            errors++;
            $display("FAIL b2b_in_ready[%0d]: got 1 while busy expected 0", k);
         end
         if (k > 0) begin
            checks++;
            if (cyc - t_prev != LAT + 2) begin
               errors++;
               $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, cyc - t_prev, LAT + 2);
            end
         end
         t_prev = cyc;
         tick();
      end
   endtask

   task automatic test_err();
      int n; bit ok;
      logic [BIN_W-1:0] eb; logic ee;
      logic [SH_W-1:0] vals[2];
      vals[0] = 12'h1A3; vals[1] = 12'h042;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         send(vals[k]);
         wait_out(n, ok);
         eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (!ok || n != LAT) begin
            errors++;
            $display("FAIL err_latency[%0d]: got %0d (seen=%0b) expected %0d", k, n, ok, LAT);
         end
         checks++;
         if (bin_out !== eb || err !== ee) begin
            errors++;
            $display("FAIL err_value[%0d]: got %0d err=%b expected %0d err=%b",
                     k, bin_out, err, eb, ee);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int n; bit ok, hold_bad;
      logic [BIN_W-1:0] eb; logic ee;
      out_ready = 1'b0;
      send(12'h507);
      wait_out(n, ok);
      eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (!ok || bin_out !== eb || err !== ee) begin
         errors++;
         $display("FAIL bp_value: got %0d err=%b (seen=%0b) expected %0d err=%b",
                  bin_out, err, ok, eb, ee);
      end
      hold_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid !== 1'b1 || bin_out !== eb || err !== ee || in_ready !== 1'b0)
            hold_bad = 1'b1;
      end
      checks++;
      if (hold_bad) begin
         errors++;
         $display("FAIL bp_hold: got out_valid=%b bin_out=%0d in_ready=%b expected 1 %0d 0",
                  out_valid, bin_out, in_ready, eb);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== eb) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b bin_out=%0d expected 0 1 %0d",
                  out_valid, in_ready, bin_out, eb);
      end
   endtask

   task automatic test_reset_mid();
      int n; bit ok, spurious;
      logic [BIN_W-1:0] eb; logic ee;
      out_ready = 1'b1;
      send(12'h888);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: in_ready=%b out_valid=%b bin_out=%0d err=%b expected 1 0 0 0",
                  in_ready, out_valid, bin_out, err);
      end
      spurious = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL rst_mid_spurious: got out_valid=1 expected 0");
      end
      send(12'h001);
      wait_out(n, ok);
      eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
      checks++;
      if (!ok || n != LAT || bin_out !== eb || err !== ee) begin
         errors++;
         $display("FAIL rst_mid_next: got %0d err=%b lat=%0d expected %0d err=%b lat=%0d",
                  bin_out, err, n, eb, ee, LAT);
      end
      tick();
   endtask

   task automatic test_exhaustive();
      int n; bit ok;
      logic [BIN_W-1:0] eb; logic ee;
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL exh_ready[%0d]: got %b expected 1", i, in_ready);
         end
         send(to_bcd(i));
         wait_out(n, ok);
         eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (!ok || n != LAT) begin
            errors++;
            $display("FAIL exh_latency[%0d]: got %0d (seen=%0b) expected %0d", i, n, ok, LAT);
         end
         checks++;
         if (bin_out !== eb || err !== 1'b0 || ee !== 1'b0) begin
            errors++;
            $display("FAIL exh_value[%0d]: got %0d err=%b expected %0d err=0", i, bin_out, err, eb);
         end
         tick();
      end
   endtask

   task automatic test_random();
      int n, stall; bit ok, hold_bad;
      logic [SH_W-1:0] v;
      logic [BIN_W-1:0] eb; logic ee;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 1) v = to_bcd(int'($urandom_range(0, 999)));
         else                           v = SH_W'($urandom_range(0, 4095));
         out_ready = 1'b0;
         send(v);
         wait_out(n, ok);
         eb = exp_q.pop_front(); ee = exp_err_q.pop_front();
         checks++;
         if (!ok || n != LAT || bin_out !== eb || err !== ee) begin
            errors++;
            $display("FAIL rnd[%0d] in=%h: got %0d err=%b lat=%0d expected %0d err=%b lat=%0d",
                     i, v, bin_out, err, n, eb, ee, LAT);
         end
         stall = int'($urandom_range(0, 3));
         hold_bad = 1'b0;
         for (int s = 0; s < stall; s++) begin
            tick();
            if (out_valid !== 1'b1 || bin_out !== eb || err !== ee) hold_bad = 1'b1;
         end
         checks++;
         if (hold_bad) begin
            errors++;
            $display("FAIL rnd_hold[%0d]: got out_valid=%b bin_out=%0d expected 1 %0d",
                     i, out_valid, bin_out, eb);
         end
         out_ready = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rnd_release[%0d]: out_valid=%b in_ready=%b expected 0 1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bcd_in = '0;
      test_reset();
      test_single_999();
      test_back_to_back();
      test_err();
      test_backpressure();
      test_reset_mid();
      test_exhaustive();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
